// File: rtl/sd_cmd_sequencer.sv
// SD CMD-line transaction sequencer: send command, capture 48-bit response, enforce Ncc gap.
// Optional macro SD_RESP_CRC_CHECK_EN adds CRC7 checking of the captured response.
module sd_cmd_sequencer #(
  parameter int unsigned CMD_WIDTH    = 38,
  parameter int unsigned RESP_LEN     = 48,
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned NCC_GAP      = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ,
  input  logic [5:0]           CMDIDX,
  input  logic [31:0]          CMDARG,
  input  logic                 RESPEXP,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT,
  output logic                 RESPERR,
  output logic [RESP_LEN-1:0]  RESP,
  output logic                 CONVENA,
  output logic [CMD_WIDTH-1:0] CONVCMD,
  input  logic                 CONVCOMPLT,
  input  logic                 SDCMDIN
);

  localparam int unsigned MAX_A    = (RESP_TIMEOUT > RESP_LEN) ? RESP_TIMEOUT : RESP_LEN;
  localparam int unsigned CNT_MAX  = (MAX_A > NCC_GAP) ? MAX_A : NCC_GAP;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned CRC_BITS = RESP_LEN - 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAITRESP,
    S_RECV,
    S_GAP
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt, cnt_inc;
  logic                  respexp_q, respexp_nxt;
  logic                  busy_nxt, done_nxt, timeout_nxt, resperr_nxt, convena_nxt;
  logic [RESP_LEN-1:0]   resp_nxt, resp_shift;
  logic [CMD_WIDTH-1:0]  convcmd_nxt;
  logic                  frame_err;
  logic                  crc_err;

  assign cnt_inc    = cnt + CNT_W'(1);
  assign resp_shift = {RESP[RESP_LEN-2:0], SDCMDIN};
  // Framing as it will look once the final (end) bit is shifted in
  assign frame_err  = resp_shift[RESP_LEN-2] | ~resp_shift[0];

`ifdef SD_RESP_CRC_CHECK_EN
  localparam logic [5:0] IDX_R3 = 6'd41;

  logic [6:0] crc_q, crc_step;

  function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign crc_step = crc7_next(crc_q, SDCMDIN);
  // R3 carries all-ones in place of a CRC
  assign crc_err  = (crc_q != resp_shift[7:1]) && (CONVCMD[CMD_WIDTH-1 -: 6] != IDX_R3);

  // CRC accumulates the start bit and the following payload bits, up to bit 8
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      crc_q <= 7'h00;
    end else if (state == S_IDLE && REQ) begin
      crc_q <= 7'h00;
    end else if ((state == S_WAITRESP && !SDCMDIN) ||
                 (state == S_RECV && cnt < CNT_W'(CRC_BITS))) begin
      crc_q <= crc_step;
    end
  end
`else
  assign crc_err = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      respexp_q <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      TIMEOUT   <= 1'b0;
      RESPERR   <= 1'b0;
      RESP      <= '0;
      CONVENA   <= 1'b0;
      CONVCMD   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      respexp_q <= respexp_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      TIMEOUT   <= timeout_nxt;
      RESPERR   <= resperr_nxt;
      RESP      <= resp_nxt;
      CONVENA   <= convena_nxt;
      CONVCMD   <= convcmd_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    respexp_nxt = respexp_q;
    busy_nxt    = BUSY;
    done_nxt    = 1'b0;
    timeout_nxt = TIMEOUT;
    resperr_nxt = RESPERR;
    resp_nxt    = RESP;
    convena_nxt = CONVENA;
    convcmd_nxt = CONVCMD;

    case (state)
      S_IDLE: begin
        if (REQ) begin
          convcmd_nxt = CMD_WIDTH'({CMDIDX, CMDARG});
          respexp_nxt = RESPEXP;
          timeout_nxt = 1'b0;
          resperr_nxt = 1'b0;
          resp_nxt    = '0;
          busy_nxt    = 1'b1;
          convena_nxt = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_SEND;
        end
      end

      S_SEND: begin
        if (CONVCOMPLT) begin
          convena_nxt = 1'b0;
          cnt_nxt     = '0;
          state_nxt   = respexp_q ? S_WAITRESP : S_GAP;
        end
      end

      S_WAITRESP: begin
        if (!SDCMDIN) begin
          resp_nxt  = resp_shift;
          cnt_nxt   = CNT_W'(1);
          state_nxt = S_RECV;
        end else if (cnt_inc == CNT_W'(RESP_TIMEOUT)) begin
          // The final silent sample cycle doubles as the first gap cycle
          timeout_nxt = 1'b1;
          cnt_nxt     = CNT_W'(1);
          state_nxt   = S_GAP;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      S_RECV: begin
        resp_nxt = resp_shift;
        cnt_nxt  = cnt_inc;
        if (cnt_inc == CNT_W'(RESP_LEN)) begin
          resperr_nxt = frame_err | crc_err;
          cnt_nxt     = '0;
          state_nxt   = S_GAP;
        end
      end

      S_GAP: begin
        if (cnt == CNT_W'(NCC_GAP)) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed-vector bench for sd_cmd_sequencer with converter and card models.
module tb_sd_cmd_sequencer;

  logic        CLK = 1'b0;
  logic        RST, REQ, RESPEXP, CONVCOMPLT, SDCMDIN;
  logic [5:0]  CMDIDX;
  logic [31:0] CMDARG;
  logic        BUSY, DONE, TIMEOUT, RESPERR, CONVENA;
  logic [47:0] RESP;
  logic [37:0] CONVCMD;

  int n_chk    = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        respexp;
    logic        send;
    logic [47:0] frame;
    logic [37:0] exp_cmd;
    logic        exp_to;
    logic        exp_err;
    logic [47:0] exp_resp;
    int          exp_lat;
    int          exp_to_cyc;
  } vec_t;

  vec_t vecs[8];
  vec_t va;

  sd_cmd_sequencer dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CMDIDX(CMDIDX), .CMDARG(CMDARG),
    .RESPEXP(RESPEXP), .BUSY(BUSY), .DONE(DONE), .TIMEOUT(TIMEOUT),
    .RESPERR(RESPERR), .RESP(RESP), .CONVENA(CONVENA), .CONVCMD(CONVCMD),
    .CONVCOMPLT(CONVCOMPLT), .SDCMDIN(SDCMDIN)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (DONE === 1'b1) done_cnt++;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic vec_t mkvec(input logic [5:0] idx, input logic [31:0] arg,
                                 input logic rexp, input logic send, input logic [47:0] frame,
                                 input logic [37:0] cmd, input logic to, input logic err,
                                 input logic [47:0] resp, input int lat, input int to_cyc);
    vec_t v;
    v.idx = idx; v.arg = arg; v.respexp = rexp; v.send = send; v.frame = frame;
    v.exp_cmd = cmd; v.exp_to = to; v.exp_err = err; v.exp_resp = resp;
    v.exp_lat = lat; v.exp_to_cyc = to_cyc;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic rexp);
    CMDIDX  = idx;
    CMDARG  = arg;
    RESPEXP = rexp;
    REQ     = 1'b1;
    step();
    REQ     = 1'b0;
  endtask

  // From the first SEND cycle: converter completes, card answers, wait for DONE
  task automatic finish_txn(input vec_t v, input int send_cycles);
    int done_cyc;
    int to_cyc;
    done_cyc = -1;
    to_cyc   = -1;
    repeat (send_cycles) step();
    CONVCOMPLT = 1'b1;
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      step();
      CONVCOMPLT = 1'b0;
      if (c == 1) begin
        check("convena_fall", 48'(CONVENA), 48'(0));
        check("busy_hold", 48'(BUSY), 48'(1));
      end
      if (TIMEOUT === 1'b1 && to_cyc < 0) to_cyc = c;
      if (DONE === 1'b1) done_cyc = c;
      else SDCMDIN = (v.send && c >= 4 && c < 52) ? v.frame[51-c] : 1'b1;
    end
    SDCMDIN = 1'b1;
    if (done_cyc < 0) begin
      n_chk++;
      $display("FAIL done_wait: got no DONE expected DONE within 200 cycles");
    end else begin
      check("done_latency", 48'(done_cyc), 48'(v.exp_lat));
      if (v.exp_to) check("timeout_cycle", 48'(to_cyc), 48'(v.exp_to_cyc));
      check("timeout", 48'(TIMEOUT), 48'(v.exp_to));
      check("resperr", 48'(RESPERR), 48'(v.exp_err));
      check("resp", RESP, v.exp_resp);
      check("busy_at_done", 48'(BUSY), 48'(0));
    end
  endtask

  task automatic run_txn(input vec_t v);
    issue(v.idx, v.arg, v.respexp);
    check("convcmd", 48'(CONVCMD), 48'(v.exp_cmd));
    check("busy_start", 48'(BUSY), 48'(1));
    check("convena_start", 48'(CONVENA), 48'(1));
    finish_txn(v, 48);
  endtask

  initial begin
    logic [47:0] f8, f8e, ftx, f41, fcrc, f2;
    logic        crc_flip_err;
    int          d0;

    RST = 1'b0; REQ = 1'b0; CMDIDX = '0; CMDARG = '0; RESPEXP = 1'b0;
    CONVCOMPLT = 1'b0; SDCMDIN = 1'b1;

    f8   = {40'h08000001AA, crc7(40'h08000001AA), 1'b1};
    f8e  = {40'h08000001AA, crc7(40'h08000001AA), 1'b0};
    ftx  = {40'h48000001AA, crc7(40'h48000001AA), 1'b1};
    f41  = {40'h3F00FF8000, 7'h7F, 1'b1};
    fcrc = {40'h08000001AA, crc7(40'h08000001AA) ^ 7'h01, 1'b1};
    f2   = {40'h0A12345678, crc7(40'h0A12345678), 1'b1};
`ifdef SD_RESP_CRC_CHECK_EN
    crc_flip_err = 1'b1;
`else
    crc_flip_err = 1'b0;
`endif

    vecs[0] = mkvec(6'd0,  32'h0,        1'b0, 1'b0, 48'h0, 38'h0000000000, 1'b0, 1'b0, 48'h0, 10, -1);
    vecs[1] = mkvec(6'd8,  32'h1AA,      1'b1, 1'b1, f8,    38'h08000001AA, 1'b0, 1'b0, f8,   61, -1);
    vecs[2] = mkvec(6'd55, 32'h0,        1'b1, 1'b0, 48'h0, 38'h3700000000, 1'b1, 1'b0, 48'h0, 73, 65);
    vecs[3] = mkvec(6'd8,  32'h1AA,      1'b1, 1'b1, f8e,   38'h08000001AA, 1'b0, 1'b1, f8e,  61, -1);
    vecs[4] = mkvec(6'd8,  32'h1AA,      1'b1, 1'b1, ftx,   38'h08000001AA, 1'b0, 1'b1, ftx,  61, -1);
    vecs[5] = mkvec(6'd41, 32'h00FF8000, 1'b1, 1'b1, f41,   38'h2900FF8000, 1'b0, 1'b0, f41,  61, -1);
    vecs[6] = mkvec(6'd8,  32'h1AA,      1'b1, 1'b1, fcrc,  38'h08000001AA, 1'b0, crc_flip_err, fcrc, 61, -1);
    vecs[7] = mkvec(6'd2,  32'h0,        1'b1, 1'b1, f2,    38'h0200000000, 1'b0, 1'b0, f2,   61, -1);
    va      = mkvec(6'd17, 32'hDEADBEEF, 1'b0, 1'b0, 48'h0, 38'h11DEADBEEF, 1'b0, 1'b0, 48'h0, 10, -1);

    // Reset state
    #2;
    check("rst_busy", 48'(BUSY), 48'(0));
    check("rst_done", 48'(DONE), 48'(0));
    check("rst_timeout", 48'(TIMEOUT), 48'(0));
    check("rst_resperr", 48'(RESPERR), 48'(0));
    check("rst_convena", 48'(CONVENA), 48'(0));
    check("rst_resp", RESP, 48'h0);
    check("rst_convcmd", 48'(CONVCMD), 48'h0);
    #10 RST = 1'b1;
    step();

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      run_txn(vecs[i]);
      step();
      check("done_pulse_width", 48'(DONE), 48'(0));
      check("done_count", 48'(done_cnt - d0), 48'(1));
    end

    // REQ during SEND with a different command is ignored
    d0 = done_cnt;
    issue(va.idx, va.arg, va.respexp);
    repeat (3) step();
    CMDIDX = 6'd18; CMDARG = 32'h12345678; RESPEXP = 1'b1; REQ = 1'b1;
    step();
    REQ = 1'b0;
    check("ignored_req_convcmd", 48'(CONVCMD), 48'(va.exp_cmd));
    finish_txn(va, 44);
    repeat (3) step();
    check("ignored_req_done_count", 48'(done_cnt - d0), 48'(1));

    // REQ in the DONE cycle is accepted
    run_txn(vecs[0]);
    issue(vecs[1].idx, vecs[1].arg, vecs[1].respexp);
    check("back_to_back_busy", 48'(BUSY), 48'(1));
    check("back_to_back_convcmd", 48'(CONVCMD), 48'(vecs[1].exp_cmd));
    finish_txn(vecs[1], 48);
    step();

    // Asynchronous reset mid-SEND drops CONVENA immediately
    issue(6'd2, 32'h0, 1'b1);
    repeat (5) step();
    check("pre_rst_convena", 48'(CONVENA), 48'(1));
    #3 RST = 1'b0;
    #1;
    check("async_rst_convena", 48'(CONVENA), 48'(0));
    check("async_rst_busy", 48'(BUSY), 48'(0));
    check("async_rst_convcmd", 48'(CONVCMD), 48'h0);
    #2 RST = 1'b1;
    step();

    // Asynchronous reset mid-RECV, then a normal CMD0
    issue(vecs[1].idx, vecs[1].arg, vecs[1].respexp);
    repeat (48) step();
    CONVCOMPLT = 1'b1;
    step();
    CONVCOMPLT = 1'b0;
    for (int c = 1; c < 12; c++) begin
      if (c >= 4) SDCMDIN = f8[51-c];
      step();
    end
    check("mid_recv_resp", RESP, 48'h08);
    check("mid_recv_busy", 48'(BUSY), 48'(1));
    #3 RST = 1'b0;
    #1;
    check("recv_rst_resp", RESP, 48'h0);
    check("recv_rst_busy", 48'(BUSY), 48'(0));
    check("recv_rst_convena", 48'(CONVENA), 48'(0));
    #2 RST = 1'b1;
    SDCMDIN = 1'b1;
    step();
    run_txn(vecs[0]);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Sequences one SD command transaction on the CMD line: latches a command request, drives the parallel-to-serial command converter, waits for and captures the 48-bit card response, then enforces the inter-command gap. It sits between the SD host control FSM (requester) and the command converter / CMD pad. It reports completion, timeout and response framing errors to the requester.

Parameters:
CMD_WIDTH, 38, command payload width {index[5:0], argument[31:0]}; must match the converter input.
RESP_LEN, 48, response frame length in bits, start bit through end bit.
RESP_TIMEOUT, 64, maximum cycles (Ncr) to wait for a response start bit after the command completes.
NCC_GAP, 8, idle cycles enforced after each transaction before DONE.

Ports:
CLK  input  1  SD clock; all state changes on rising edge.
RST  input  1  asynchronous, active-low reset.
REQ  input  1  start request; sampled only in IDLE.
CMDIDX  input  6  command index.
CMDARG  input  32  command argument.
RESPEXP  input  1  1 = a 48-bit response is expected.
BUSY  output  1  transaction in progress.
DONE  output  1  one-cycle completion pulse.
TIMEOUT  output  1  no response start bit within RESP_TIMEOUT; valid from DONE until next accepted REQ.
RESPERR  output  1  response framing (or CRC, see option) error; same validity as TIMEOUT.
RESP  output  48  captured response frame, MSB = start bit.
CONVENA  output  1  enable to the command converter.
CONVCMD  output  CMD_WIDTH  payload to the converter.
CONVCOMPLT  input  1  converter finished shifting the frame.
SDCMDIN  input  1  sampled CMD line (pulled up; idle = 1).

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; BUSY, DONE, TIMEOUT, RESPERR, CONVENA = 0; RESP, CONVCMD = 0; all counters 0. Reset mid-transaction aborts immediately; CONVENA drops without waiting for a clock.
- States: IDLE, SEND, WAITRESP, RECV, GAP.
- IDLE: REQ=1 -> latch CONVCMD={CMDIDX,CMDARG}, RESPEXP; clear TIMEOUT, RESPERR, RESP; BUSY=1 and CONVENA=1 from the next cycle; go SEND. REQ while BUSY=1 is ignored (no queueing).
- SEND: CONVENA held 1, CONVCMD stable. On CONVCOMPLT=1: CONVENA=0 next cycle; go WAITRESP (counter cleared) if RESPEXP=1, else GAP.
- WAITRESP: counter increments each cycle. SDCMDIN=0 -> RESP shift begins with that bit as bit 1 of 48; go RECV. If the counter reaches RESP_TIMEOUT with no 0 sampled: TIMEOUT=1, go GAP. If a start bit and the limit coincide, the start bit wins.
- RECV: shift SDCMDIN into RESP LSB, MSB-first; after the 48th bit, go GAP. Check: RESP[46] (transmission bit) must be 0 and RESP[0] (end bit) must be 1, otherwise RESPERR=1.
- GAP: count NCC_GAP cycles. Then DONE=1 for exactly one cycle, BUSY=0 in that same cycle, state IDLE. A REQ in the DONE cycle is accepted.
- Total latency, no response: DONE asserts NCC_GAP+2 cycles after CONVCOMPLT.
- RESP, TIMEOUT, RESPERR hold their values until the next accepted REQ.

Optional Feature:
SD_RESP_CRC_CHECK_EN: when defined, a serial CRC7 (x^7+x^3+1) runs over RESP bits 47..8 during RECV and is compared with bits 7..1. A mismatch sets RESPERR, except when the latched CMDIDX is 41 (R3, CRC field all ones). When undefined, the CRC field is captured but ignored, and RESPERR reflects framing only.

Test Plan:
- CMD0 (idx 0, arg 0, RESPEXP=0), converter model raises COMPLT 48 cycles after CONVENA -> CONVCMD=38'h0; CONVENA falls 1 cycle after COMPLT; DONE after NCC_GAP+2 cycles; TIMEOUT=0, RESPERR=0.
- CMD8 (idx 8, arg 32'h1AA, RESPEXP=1), card model drives 48'h08_000001AA plus a valid CRC7 and end bit 4 cycles after COMPLT -> RESP[47:8]=40'h08000001AA; RESPERR=0 (also with SD_RESP_CRC_CHECK_EN); DONE pulse once.
- CMD55, RESPEXP=1, SDCMDIN held 1 -> TIMEOUT=1 exactly RESP_TIMEOUT cycles after entering WAITRESP; DONE follows NCC_GAP cycles later.
- Response with end bit 0 -> RESPERR=1; with the option enabled, 1 flipped CRC bit -> RESPERR=1; idx 41 with CRC 7'h7F -> RESPERR=0.
- REQ pulsed during SEND with different idx -> ignored; CONVCMD unchanged; only one DONE.
- RST=0 asserted mid-RECV between clock edges -> CONVENA, BUSY, RESP clear immediately; after release, a new CMD0 completes normally.
